axi_read_arbiter: RTL and testbench

Shares the single AXI read-address/read-data channel pair (m_axi_ar*/m_axi_r*) between the instruction cache and the data cache miss engines. Accepts one line-fill request at a time from either cache, with round-robin priority, and issues it as a fixed-length INCR burst. Routes the returned beats to the owning cache and flags malformed bursts. Sits between the two directCache instances and the top-level AXI master ports; the write channels are not touched.

---
 rtl/axi_read_arbiter.sv | 143 ++++++++++++++
 tb/tb_axi_read_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read channel between the I-cache and D-cache
// fill engines: one fixed-length INCR burst outstanding, beats routed to the owner.
module axi_read_arbiter #(
  parameter int ID_WIDTH    = 13,
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int BURST_BEATS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ireq_valid,
  input  logic [ADDR_WIDTH-1:0] ireq_addr,
  output logic                  ireq_ready,
  output logic [DATA_WIDTH-1:0] iresp_data,
  output logic                  iresp_valid,
  output logic                  iresp_last,
  output logic                  iresp_err,
  input  logic                  dreq_valid,
  input  logic [ADDR_WIDTH-1:0] dreq_addr,
  output logic                  dreq_ready,
  output logic [DATA_WIDTH-1:0] dresp_data,
  output logic                  dresp_valid,
  output logic                  dresp_last,
  output logic                  dresp_err,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  protocol_err,
  output logic [1:0]            state_dbg
);

  localparam int OFFS = $clog2(BURST_BEATS * DATA_WIDTH / 8);
  localparam int CW   = $clog2(BURST_BEATS);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << OFFS) - ADDR_WIDTH'(1));
  localparam logic [CW-1:0] LAST_CNT = CW'(BURST_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                state, next_state;
  logic                  owner;       // 0 = I-cache, 1 = D-cache
  logic                  last_grant;  // 0 = I-cache, 1 = D-cache
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            prot_q;
  logic                  perr;
  logic                  grant_i, grant_d, beat;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  unused_bits;

  // Handshakes: a request transfers when req_valid && req_ready (ready is a
  // one-cycle pulse); AR transfers on arvalid && arready; R beats on rvalid && rready.
  always_comb begin
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    next_state = state;
    req_addr   = ireq_addr;
    beat       = (state == DATA) && m_axi_rvalid;
    case (state)
      IDLE: begin
        grant_i = ireq_valid && (!dreq_valid || last_grant);
        grant_d = dreq_valid && (!ireq_valid || !last_grant);
        if (grant_d) req_addr = dreq_addr;
        if (grant_i || grant_d) next_state = ADDR;
      end
      ADDR: if (m_axi_arready) next_state = DATA;
      DATA: if (m_axi_rvalid && m_axi_rlast) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      addr_q     <= '0;
      prot_q     <= '0;
      perr       <= 1'b0;
    end else begin
      state <= next_state;
      if (grant_i || grant_d) begin
        owner      <= grant_d;
        last_grant <= grant_d;
        addr_q     <= req_addr & ALIGN_MASK;
        prot_q     <= {grant_i, 2'b00};
      end
      if (state == ADDR && m_axi_arready) cnt <= '0;
      if (beat) begin
        cnt <= cnt + CW'(1);
        // Early rlast, or a full count that wraps without rlast, is malformed.
        if (m_axi_rlast && cnt != LAST_CNT) perr <= 1'b1;
        if (!m_axi_rlast && cnt == LAST_CNT) perr <= 1'b1;
      end
    end
  end

  assign ireq_ready    = grant_i;
  assign dreq_ready    = grant_d;
  assign m_axi_arid    = {{(ID_WIDTH-1){1'b0}}, owner};
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'(BURST_BEATS - 1);
  assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0000;
  assign m_axi_arprot  = prot_q;
  assign m_axi_arvalid = (state == ADDR);
  assign m_axi_rready  = (state == DATA);
  assign protocol_err  = perr;
  assign state_dbg     = state;

  // Routing follows the registered owner only; rid is ignored.
  assign iresp_valid = beat && !owner;
  assign iresp_data  = iresp_valid ? m_axi_rdata : '0;
  assign iresp_last  = iresp_valid && m_axi_rlast;
  assign iresp_err   = iresp_valid && m_axi_rresp[1];
  assign dresp_valid = beat && owner;
  assign dresp_data  = dresp_valid ? m_axi_rdata : '0;
  assign dresp_last  = dresp_valid && m_axi_rlast;
  assign dresp_err   = dresp_valid && m_axi_rresp[1];

  assign unused_bits = ^{m_axi_rid, m_axi_rresp[0]};

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: a table of fill transactions plus
// hand-written reset-state and mid-burst-reset sequences.
module tb_axi_read_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid, dreq_valid;
  logic [63:0] ireq_addr, dreq_addr;
  logic        ireq_ready, dreq_ready;
  logic [63:0] iresp_data, dresp_data;
  logic        iresp_valid, iresp_last, iresp_err;
  logic        dresp_valid, dresp_last, dresp_err;
  logic [12:0] m_axi_arid, m_axi_rid;
  logic [63:0] m_axi_araddr, m_axi_rdata;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize, m_axi_arprot;
  logic [1:0]  m_axi_arburst, m_axi_rresp;
  logic        m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic        m_axi_arvalid, m_axi_arready;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic        protocol_err;
  logic [1:0]  state_dbg;

  int total  = 0;
  int passed = 0;

  axi_read_arbiter dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_ready(ireq_ready),
    .iresp_data(iresp_data), .iresp_valid(iresp_valid), .iresp_last(iresp_last),
    .iresp_err(iresp_err),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_ready(dreq_ready),
    .dresp_data(dresp_data), .dresp_valid(dresp_valid), .dresp_last(dresp_last),
    .dresp_err(dresp_err),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .protocol_err(protocol_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        dv;
    logic [63:0] ia;
    logic [63:0] da;
    int          ar_wait;
    int          last_beat;
    int          err_beat;
    logic        exp_d;
    logic [63:0] exp_addr;
    logic        exp_perr;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else
      passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v);
    logic [63:0] dat;
    ireq_valid = v.iv; ireq_addr = v.ia;
    dreq_valid = v.dv; dreq_addr = v.da;
    @(negedge clk);
    check("grant_i", ireq_ready, !v.exp_d);
    check("grant_d", dreq_ready, v.exp_d);
    check("idle_arvalid", m_axi_arvalid, 0);
    step();
    if (v.exp_d) dreq_valid = 1'b0; else ireq_valid = 1'b0;
    for (int w = 0; w < v.ar_wait; w++) begin
      m_axi_arready = 1'b0;
      @(negedge clk);
      check("wait_arvalid", m_axi_arvalid, 1);
      check("wait_araddr", m_axi_araddr, v.exp_addr);
      check("wait_arid", m_axi_arid, v.exp_d);
      check("wait_rready", m_axi_rready, 0);
      step();
    end
    m_axi_arready = 1'b1;
    @(negedge clk);
    check("arvalid", m_axi_arvalid, 1);
    check("araddr", m_axi_araddr, v.exp_addr);
    check("arid", m_axi_arid, v.exp_d);
    check("arprot", m_axi_arprot, v.exp_d ? 3'b000 : 3'b100);
    check("arlen", m_axi_arlen, 8'd7);
    check("ar_rready", m_axi_rready, 0);
    step();
    m_axi_arready = 1'b0;
    for (int b = 0; b <= v.last_beat; b++) begin
      dat = {v.exp_addr[31:0], 32'(b) ^ 32'hA5A5_0000};
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = dat;
      m_axi_rid    = 13'(v.exp_d);
      m_axi_rlast  = (b == v.last_beat);
      m_axi_rresp  = (b == v.err_beat) ? 2'b10 : 2'b00;
      @(negedge clk);
      check("rready", m_axi_rready, 1);
      check("own_valid", v.exp_d ? dresp_valid : iresp_valid, 1);
      check("own_data", v.exp_d ? dresp_data : iresp_data, dat);
      check("own_last", v.exp_d ? dresp_last : iresp_last, b == v.last_beat);
      check("own_err", v.exp_d ? dresp_err : iresp_err, b == v.err_beat);
      check("other_valid", v.exp_d ? iresp_valid : dresp_valid, 0);
      step();
    end
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
    ireq_valid = 1'b0; dreq_valid = 1'b0;
    @(negedge clk);
    check("end_state_idle", state_dbg, 2'd0);
    check("end_rready", m_axi_rready, 0);
    check("end_arvalid", m_axi_arvalid, 0);
    check("protocol_err", protocol_err, v.exp_perr);
    step();
  endtask

  initial begin
    //         iv    dv    ia          da          wait last err exp_d exp_addr    perr
    tbl[0] = '{1'b1, 1'b1, 64'h1234, 64'h3048, 0, 7, -1, 1'b0, 64'h1200, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 64'h2000, 64'h3048, 0, 7, -1, 1'b1, 64'h3040, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 64'h2000, 64'h5000, 0, 7, -1, 1'b0, 64'h2000, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 64'h0,    64'h40FF, 5, 7,  3, 1'b1, 64'h40C0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 64'h7777, 64'h0,    0, 3, -1, 1'b0, 64'h7740, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 64'h0,    64'h8000, 0, 7, -1, 1'b1, 64'h8000, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 64'h0,    64'hA000, 0, 7, -1, 1'b1, 64'hA000, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 64'hB000, 64'hC000, 0, 7, -1, 1'b0, 64'hB000, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 64'h0,    64'hD008, 0, 9, -1, 1'b1, 64'hD000, 1'b1};

    reset = 1'b1;
    ireq_valid = 1'b0; dreq_valid = 1'b0; ireq_addr = '0; dreq_addr = '0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rid = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state with no requests pending.
    @(negedge clk);
    check("rst_state", state_dbg, 2'd0);
    check("rst_arvalid", m_axi_arvalid, 0);
    check("rst_rready", m_axi_rready, 0);
    check("rst_araddr", m_axi_araddr, 0);
    check("rst_arid", m_axi_arid, 0);
    check("rst_arprot", m_axi_arprot, 0);
    check("rst_arlen", m_axi_arlen, 8'd7);
    check("rst_arsize", m_axi_arsize, 3'd3);
    check("rst_arburst", m_axi_arburst, 2'b01);
    check("rst_lock_cache", {m_axi_arlock, m_axi_arcache}, 0);
    check("rst_ready", {ireq_ready, dreq_ready}, 0);
    check("rst_perr", protocol_err, 0);
    step();

    for (int i = 0; i <= 5; i++) run_txn(tbl[i]);

    // Asynchronous reset in the middle of a D burst, on its fourth beat.
    dreq_valid = 1'b1; dreq_addr = 64'hE000;
    @(negedge clk);
    check("mr_grant_d", dreq_ready, 1);
    step();
    dreq_valid = 1'b0; m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      m_axi_rvalid = 1'b1; m_axi_rdata = 64'(b);
      step();
    end
    m_axi_rvalid = 1'b1; m_axi_rdata = 64'h3;
    @(negedge clk);
    check("mr_pre_valid", dresp_valid, 1);
    #1 reset = 1'b1;
    #1;
    check("mr_arvalid", m_axi_arvalid, 0);
    check("mr_rready", m_axi_rready, 0);
    check("mr_resp_valid", {iresp_valid, dresp_valid}, 0);
    check("mr_state", state_dbg, 2'd0);
    check("mr_perr", protocol_err, 0);
    step();
    step();
    reset = 1'b0; m_axi_rvalid = 1'b0;
    step();

    for (int i = 6; i <= 8; i++) run_txn(tbl[i]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
